// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Arbitrates two requesters (0 = PC/fetch, 1 = ALU) onto one shared,
//   purely combinational 4-bit ADDER slice.
//   - Grants one request per IDLE -> EXEC -> RESP round.
//   - Drives the ADDER inputs during EXEC only.
//   - Registers the ADDER result and flag.
//   - Returns the result with a one-cycle ACK pulse to the granted requester.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   REQ0/IN0_A/IN0_B/SEL0 requester 0 request, operands, ADDER select
//   REQ1/IN1_A/IN1_B/SEL1 requester 1 request, operands, ADDER select
//   ACK0, ACK1            one-cycle pulse: RES/RFLG valid for that requester
//   RES, RFLG             registered ADDER OUT/FLG of last completed operation
//   BUSY                  high while in EXEC or RESP
//   ADD_IN1/ADD_IN2/ADD_SEL  to ADDER; zero outside EXEC
//   ADD_OUT/ADD_FLG       from ADDER
// Parameter
//   PRIO_MODE             1 = round-robin on ties, 0 = requester 0 always wins
// -----------------------------------------------------------------------------
module adder_arbiter #(
    parameter bit PRIO_MODE = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic [3:0] IN0_A,
    input  logic [3:0] IN0_B,
    input  logic [1:0] SEL0,
    input  logic       REQ1,
    input  logic [3:0] IN1_A,
    input  logic [3:0] IN1_B,
    input  logic [1:0] SEL1,
    output logic       ACK0,
    output logic       ACK1,
    output logic [3:0] RES,
    output logic       RFLG,
    output logic       BUSY,
    output logic [3:0] ADD_IN1,
    output logic [3:0] ADD_IN2,
    output logic [1:0] ADD_SEL,
    input  logic [3:0] ADD_OUT,
    input  logic       ADD_FLG
);

    localparam int unsigned DW = 4;
    localparam int unsigned SW = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            gnt;
    logic            gnt_nxt;
    logic            last;
    logic            last_nxt;
    logic            winner;
    logic            ack0_nxt;
    logic            ack1_nxt;
    logic [DW-1:0]   res_nxt;
    logic            rflg_nxt;

    // State and registered outputs; reset aborts any operation in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
            RES   <= '0;
            RFLG  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            ACK0  <= ack0_nxt;
            ACK1  <= ack1_nxt;
            RES   <= res_nxt;
            RFLG  <= rflg_nxt;
            BUSY  <= (state_nxt != S_IDLE);
        end
    end

    // Next-state, grant selection and ADDER drive
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        winner    = 1'b0;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        res_nxt   = RES;
        rflg_nxt  = RFLG;
        ADD_IN1   = '0;
        ADD_IN2   = '0;
        ADD_SEL   = '0;

        case (state)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    // On a tie, round-robin favours whoever did not win last
                    if (REQ0 && REQ1) begin
                        winner = PRIO_MODE ? ~last : 1'b0;
                    end else begin
                        winner = REQ1;
                    end
                    gnt_nxt   = winner;
                    last_nxt  = winner;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                // Operands are taken live from the granted requester
                ADD_IN1   = gnt ? IN1_A : IN0_A;
                ADD_IN2   = gnt ? IN1_B : IN0_B;
                ADD_SEL   = gnt ? SW'(SEL1) : SW'(SEL0);
                res_nxt   = DW'(ADD_OUT);
                rflg_nxt  = ADD_FLG;
                ack0_nxt  = ~gnt;
                ack1_nxt  = gnt;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
